bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
Microsequencer that moves one data word between bus-attached registers (or loads an immediate) over the shared tristate data bus. It drives the per-register CS/WE/OE strobes so that exactly one source drives the bus while one destination latches it. It is the only block allowed to generate register strobes, and it guarantees the bus never has two drivers. Sits between the instruction decoder (requester) and the register bank.

Parameters:
DATA_WIDTH, `DATA_WIDTH, width of the data bus and immediate
N_REGS, 4, number of bus-attached registers controlled (indices 0..N_REGS-1)
SEL_W, 3, width of the source/destination select fields; must hold the value N_REGS

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  transfer request present
req_ready  out  1  controller can accept a request (high only in IDLE)
req_src  in  SEL_W  source index; value N_REGS selects the immediate
req_dst  in  SEL_W  destination index, 0..N_REGS-1
req_imm  in  DATA_WIDTH  immediate word, used when req_src == N_REGS
cs  out  N_REGS  per-register chip select
we  out  N_REGS  per-register write enable
oe  out  N_REGS  per-register output enable
bus_out  out  DATA_WIDTH  immediate value driven onto the bus
bus_oe  out  1  controller drives bus_out onto the data bus
busy  out  1  transfer in progress (state != IDLE)
done  out  1  one-cycle pulse: transfer finished or rejected
err  out  1  one-cycle pulse, coincident with done, on rejected request

Behaviour:
- Reset (reset low, asynchronous): state IDLE; cs, we, oe = 0; bus_oe = 0; bus_out = 0; done = err = busy = 0; req_ready = 1 once reset is released. Reset mid-transfer aborts immediately; all strobes drop in the same instant and the destination is not written.
- Handshake: request accepted on a rising edge with req_valid & req_ready. req_src, req_dst and req_imm are captured into internal registers; the inputs are ignored after acceptance.
- States: IDLE -> DRIVE -> WRITE -> DONE -> IDLE for a legal request; IDLE -> DONE -> IDLE for a rejected one.
- DRIVE (1 cycle): source bus driver enabled, either cs[src] & oe[src] or bus_oe with bus_out = captured imm. we = 0. Gives the bus one cycle to settle.
- WRITE (1 cycle): source driver still enabled; cs[dst] & we[dst] asserted. The destination latch is transparent and its flop captures on the edge leaving WRITE.
- DONE (1 cycle): all strobes 0, bus_oe 0, done = 1, busy = 1, req_ready = 0. Next state is IDLE.
- Latency for a legal request: accept edge to done high = 3 cycles. Back-to-back requests are accepted every 4 cycles.
- Rejection: src == dst, dst >= N_REGS, or src > N_REGS. DONE is entered directly with err = 1, no strobe is asserted, and no register is modified.
- Invariants, checked every cycle:
  - at most one of {oe bits, bus_oe} is high;
  - at most one we bit is high;
  - we[i] implies cs[i];
  - oe[i] implies cs[i];
  - we never rises in the same cycle a bus driver first turns on.
- All outputs are registered, decoded from state and the captured fields. There are no combinational paths from req_* to the strobes.

Optional Feature:
XFER_STATS_EN: when defined, adds output xfer_count (16 bits) and input stats_clr (1 bit).
- xfer_count increments on every legal completed transfer and saturates at 16'hFFFF.
- Rejected requests are not counted.
- stats_clr zeroes the count synchronously; it has priority over an increment in the same cycle.
- Reset clears the count to 0.
When XFER_STATS_EN is not defined, neither port exists and no counter logic is present.

Test Plan:
- Reset: hold reset low with req_valid = 1 -> all strobes 0, req_ready = 0. Release reset -> req_ready = 1 and no transfer starts until the next edge.
- Immediate load: src = 4 (N_REGS), dst = 2, imm = 8'hA5.
  - DRIVE: bus_oe = 1, bus_out = A5.
  - WRITE: additionally cs = 4'b0100, we = 4'b0100.
  - done pulses 3 cycles after accept; register 2 then reads A5.
- Register move: r1 = 8'h3C, request src = 1, dst = 3.
  - DRIVE: oe = 0010, cs = 0010.
  - WRITE: cs = 1010, we = 1000, oe = 0010.
  - After done, r3 = 3C and r1 is unchanged.
- Rejects: src = 2, dst = 2 -> done & err on the cycle after accept, zero strobes. dst = 5 gives the same result.
- Abort: assert reset low during WRITE of src = 0, dst = 1 -> strobes drop asynchronously and r1 keeps its old value.
- Stats (XFER_STATS_EN): 3 legal transfers and 1 reject -> xfer_count = 3. Pulse stats_clr coincident with a completion -> xfer_count = 0.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: microsequencer that moves one word between bus-attached
// registers, or loads an immediate, over the shared data bus.
// It drives the per-register cs/we/oe strobes so the bus has at most one
// driver at any time.
//
// Request handshake: a request is taken on a rising clk edge where
// req_valid and req_ready are both high. req_ready is high only while
// idle. Once taken, req_src/req_dst/req_imm are captured and the request
// inputs are ignored until the controller is idle again.
//
// Optional feature: define XFER_STATS_EN to add the saturating xfer_count
// output and the stats_clr input.
// state_dbg exposes the FSM state for checkers.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module bus_xfer_ctrl #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int N_REGS     = 4,
    parameter int SEL_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEL_W-1:0]      req_src,
    input  logic [SEL_W-1:0]      req_dst,
    input  logic [DATA_WIDTH-1:0] req_imm,
    output logic [N_REGS-1:0]     cs,
    output logic [N_REGS-1:0]     we,
    output logic [N_REGS-1:0]     oe,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_oe,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
`ifdef XFER_STATS_EN
    output logic [15:0]           xfer_count,
    input  logic                  stats_clr,
`endif
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] dst_q;
    logic             req_bad;

    // Index to one-hot register select; the immediate index maps to no register.
    function automatic logic [N_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (idx == SEL_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Illegal request: self-move, nonexistent destination or out-of-range source.
    always_comb begin
        req_bad = (req_src == req_dst) ||
                  (req_dst >= SEL_W'(N_REGS)) ||
                  (req_src >  SEL_W'(N_REGS));
    end

    assign state_dbg = state;

    // Transfer sequencer; every output is a register set on the edge entering its phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            dst_q     <= '0;
            cs        <= '0;
            we        <= '0;
            oe        <= '0;
            bus_out   <= '0;
            bus_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        dst_q     <= req_dst;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_bad) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= S_DRIVE;
                            if (req_src == SEL_W'(N_REGS)) begin
                                bus_oe  <= 1'b1;
                                bus_out <= req_imm;
                            end else begin
                                cs <= sel_onehot(req_src);
                                oe <= sel_onehot(req_src);
                            end
                        end
                    end
                end
                S_DRIVE: begin
                    // Source has had a full cycle to settle; open the destination.
                    state <= S_WRITE;
                    cs    <= cs | sel_onehot(dst_q);
                    we    <= sel_onehot(dst_q);
                end
                S_WRITE: begin
                    state   <= S_DONE;
                    cs      <= '0;
                    we      <= '0;
                    oe      <= '0;
                    bus_oe  <= 1'b0;
                    bus_out <= '0;
                    done    <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef XFER_STATS_EN
    // Saturating count of legal completed transfers; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_count <= '0;
        end else if (stats_clr) begin
            xfer_count <= '0;
        end else if (state == S_DONE && !err && xfer_count != 16'hFFFF) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a model register bank on a muxed data bus,
// table-driven directed transfers, hand sequences for reset/abort,
// randomized transfers against a word-level reference model, and a
// per-cycle monitor for the bus/strobe invariants.
module tb_bus_xfer_ctrl;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_src;
    logic [2:0] req_dst;
    logic [7:0] req_imm;
    logic [3:0] cs;
    logic [3:0] we;
    logic [3:0] oe;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] state_dbg;
`ifdef XFER_STATS_EN
    logic [15:0] xfer_count;
    logic        stats_clr;
`endif

    int checks = 0;
    int failures = 0;

    bus_xfer_ctrl #(.DATA_WIDTH(8), .N_REGS(4), .SEL_W(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
        .cs(cs), .we(we), .oe(oe), .bus_out(bus_out), .bus_oe(bus_oe),
        .busy(busy), .done(done), .err(err),
`ifdef XFER_STATS_EN
        .xfer_count(xfer_count), .stats_clr(stats_clr),
`endif
        .state_dbg(state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model register bank and data bus
    logic [7:0] bank [4] = '{default: 8'h00};
    logic [7:0] bus_val;
    always_comb begin
        bus_val = 8'h00;
        if (bus_oe) bus_val = bus_out;
        for (int i = 0; i < 4; i++) if (oe[i]) bus_val = bank[i];
    end
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (cs[i] && we[i]) bank[i] <= bus_val;
    end

    // Reference model contents, at the level of "dst := src word"
    logic [7:0] ref_regs [4] = '{default: 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Invariant monitor, sampled on the falling edge
    logic prev_drv = 1'b0;
    logic [3:0] prev_we = 4'b0;
    always @(negedge clk) begin
        if (reset) begin
            chk("inv_one_driver", 32'($countones({oe, bus_oe}) <= 1), 32'd1);
            chk("inv_one_we", 32'($countones(we) <= 1), 32'd1);
            chk("inv_we_cs", 32'(we & ~cs), 32'd0);
            chk("inv_oe_cs", 32'(oe & ~cs), 32'd0);
            chk("inv_we_drv_rise",
                32'((we != 0) && (prev_we == 0) && ((oe != 0) || bus_oe) && !prev_drv), 32'd0);
        end
        prev_drv = (oe != 0) || bus_oe;
        prev_we  = we;
    end

    typedef struct packed {
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] imm;
        logic       e_err;
        logic [3:0] d_cs;
        logic [3:0] d_oe;
        logic       d_boe;
        logic [3:0] w_cs;
        logic [3:0] w_we;
        logic [3:0] w_oe;
    } vec_t;

    // Expectations for a request derived directly from the legality and strobe rules
    function automatic vec_t model_vec(input logic [2:0] s, input logic [2:0] d, input logic [7:0] im);
        vec_t v;
        int si, di;
        si = int'(s);
        di = int'(d);
        v = '0;
        v.src = s; v.dst = d; v.imm = im;
        v.e_err = (si == di) || (di >= 4) || (si > 4);
        if (!v.e_err) begin
            v.d_boe = (si == 4);
            v.d_cs  = (si < 4) ? 4'(1 << si) : 4'b0;
            v.d_oe  = v.d_cs;
            v.w_we  = 4'(1 << di);
            v.w_cs  = v.d_cs | v.w_we;
            v.w_oe  = v.d_oe;
        end
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < 4; i++) chk({tag, "_bank"}, 32'(bank[i]), 32'(ref_regs[i]));
    endtask

    // Issue one request and check every phase; caller sits at #1 after a posedge.
    task automatic apply_vec(input vec_t v);
        wait_ready();
        req_valid = 1'b1; req_src = v.src; req_dst = v.dst; req_imm = v.imm;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_src = 3'($urandom_range(0, 7)); req_dst = 3'($urandom_range(0, 7));
        req_imm = 8'($urandom);
        if (v.e_err) begin
            chk("rej_done", 32'({done, err, busy, req_ready}), 32'b1110);
            chk("rej_strobes", 32'({cs, we, oe, bus_oe}), 32'd0);
            @(posedge clk); #1;
        end else begin
            chk("drv_cs_oe_boe", 32'({cs, oe, bus_oe}), 32'({v.d_cs, v.d_oe, v.d_boe}));
            chk("drv_we_done", 32'({we, done, busy, req_ready}), 32'b0000_0_1_0);
            if (v.d_boe) chk("drv_bus_out", 32'(bus_out), 32'(v.imm));
            @(posedge clk); #1;
            chk("wr_cs_we_oe", 32'({cs, we, oe, bus_oe}), 32'({v.w_cs, v.w_we, v.w_oe, v.d_boe}));
            @(posedge clk); #1;
            chk("done_phase", 32'({done, err, busy, req_ready}), 32'b1010);
            chk("done_strobes", 32'({cs, we, oe, bus_oe}), 32'd0);
            ref_regs[int'(v.dst)] = (v.src == 3'd4) ? v.imm : ref_regs[int'(v.src)];
            @(posedge clk); #1;
        end
        chk("idle_after", 32'({done, err, busy, req_ready}), 32'b0001);
        check_bank("xfer");
    endtask

    vec_t tbl [8];
    int n_legal;

    initial begin
        req_valid = 1'b0; req_src = 3'd0; req_dst = 3'd0; req_imm = 8'h00;
`ifdef XFER_STATS_EN
        stats_clr = 1'b0;
`endif
        // Directed table
        tbl[0] = '{3'd4, 3'd2, 8'hA5, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0100, 4'b0000};
        tbl[1] = '{3'd4, 3'd1, 8'h3C, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0010, 4'b0000};
        tbl[2] = '{3'd1, 3'd3, 8'hFF, 1'b0, 4'b0010, 4'b0010, 1'b0, 4'b1010, 4'b1000, 4'b0010};
        tbl[3] = '{3'd2, 3'd2, 8'h11, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 4'b0, 4'b0};
        tbl[4] = '{3'd0, 3'd5, 8'h22, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 4'b0, 4'b0};
        tbl[5] = '{3'd5, 3'd0, 8'h33, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 4'b0, 4'b0};
        tbl[6] = '{3'd3, 3'd0, 8'h44, 1'b0, 4'b1000, 4'b1000, 1'b0, 4'b1001, 4'b0001, 4'b1000};
        tbl[7] = '{3'd4, 3'd4, 8'h55, 1'b1, 4'b0, 4'b0, 1'b0, 4'b0, 4'b0, 4'b0};

        // Reset held with a pending request
        reset = 1'b0;
        req_valid = 1'b1; req_src = 3'd4; req_dst = 3'd0; req_imm = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({cs, we, oe, bus_oe, bus_out}), 32'd0);
        chk("rst_flags", 32'({req_ready, busy, done, err}), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'({req_ready, busy}), 32'b10);
        chk("post_rst_idle", 32'(state_dbg), 32'd0);

        for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

        // Abort during WRITE of r0 -> r1
        apply_vec(model_vec(3'd4, 3'd0, 8'h5A));
        apply_vec(model_vec(3'd4, 3'd1, 8'h11));
        wait_ready();
        req_valid = 1'b1; req_src = 3'd0; req_dst = 3'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_write", 32'({cs, we}), 32'b0011_0010);
        #2 reset = 1'b0;
        #1;
        chk("abort_strobes", 32'({cs, we, oe, bus_oe}), 32'd0);
        chk("abort_flags", 32'({busy, done, req_ready}), 32'd0);
        @(posedge clk); #1;
        check_bank("abort");
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", 32'(req_ready), 32'd1);

        // Randomized transfers
        for (int i = 0; i < 40; i++) begin
            logic [2:0] s, d;
            if ($urandom_range(0, 3) == 0) begin
                s = 3'($urandom_range(0, 7)); d = 3'($urandom_range(0, 7));
            end else begin
                s = 3'($urandom_range(0, 4)); d = 3'($urandom_range(0, 3));
            end
            apply_vec(model_vec(s, d, 8'($urandom)));
        end

`ifdef XFER_STATS_EN
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        chk("stats_cleared", 32'(xfer_count), 32'd0);
        n_legal = 0;
        apply_vec(model_vec(3'd4, 3'd0, 8'h01));
        apply_vec(model_vec(3'd0, 3'd2, 8'h00));
        apply_vec(model_vec(3'd1, 3'd1, 8'h00));
        apply_vec(model_vec(3'd2, 3'd3, 8'h00));
        chk("stats_count3", 32'(xfer_count), 32'd3);
        // Clear coincident with a completion
        wait_ready();
        req_valid = 1'b1; req_src = 3'd4; req_dst = 3'd3; req_imm = 8'h9C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("stats_done_seen", 32'(done), 32'd1);
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        ref_regs[3] = 8'h9C;
        chk("stats_clr_prio", 32'(xfer_count), 32'd0);
`else
        n_legal = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_bank("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
